helper_axis_stream_generator: RTL

Parametrised AXI-Stream stimulus source for test benches: next generation of the single-mode AXIS data generator. Emits a configurable number of beats as a counter sequence, a 32-bit LFSR sequence or a constant. Asserts `output_last` on packet boundaries and `done` after the final beat. Holds every offered beat stable under back-pressure, so it can drive any AXIS slave under test, including ones that stall.

---
 rtl/helper_axis_stream_generator.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/helper_axis_stream_generator.sv
// helper_axis_stream_generator
//
// Parametrised AXI-Stream stimulus source. Emits beats taken from a counter,
// a 32-bit Galois LFSR or a constant. It marks packet boundaries on
// output_last and raises a sticky done flag once BEAT_COUNT beats have been
// accepted. An offered beat is held stable until it is accepted.
//
// Optional feature: define HELPER_AXIS_GEN_THROTTLE_EN to insert
// pseudo-random idle gaps of 0..3 cycles between beats. The gap lengths
// come from an 8-bit LFSR.
//
// Handshake: a beat transfers on a rising edge where output_valid and
// output_ready are both 1. Once output_valid is 1, it stays 1 and
// output_data/output_last stay constant until that transfer. Only rst
// drops a pending beat.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   enable       in   permission to start or continue offering beats
//   output_valid out  AXIS tvalid (registered)
//   output_data  out  AXIS tdata, DATA_WIDTH bits (registered)
//   output_last  out  AXIS tlast (registered)
//   output_ready in   AXIS tready
//   done         out  sticky: all BEAT_COUNT beats accepted
//   beat_count   out  accepted beats, saturating at 2^32-1
//
// The FSM state register state_q (type state_e) is the debug hook for
// bound checkers.
module helper_axis_stream_generator #(
  parameter int          DATA_WIDTH  = 10,
  parameter int          MODE        = 0,
  parameter logic [31:0] START_VALUE = 32'd0,
  parameter logic [31:0] STEP        = 32'd1,
  parameter logic [31:0] SEED        = 32'h1,
  parameter logic [31:0] BEAT_COUNT  = 32'd0,
  parameter logic [31:0] LAST_PERIOD = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_last,
  input  logic                  output_ready,
  output logic                  done,
  output logic [31:0]           beat_count
);

  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - DATA_WIDTH);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SRC_RESET = (MODE == 1) ? SEED : (START_VALUE & DATA_MASK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [31:0] src_q, src_d;
  logic [31:0] count_q, count_d;
  logic [31:0] period_q, period_d;

  logic        hs;
  logic [31:0] src_next;
  logic [31:0] count_next;
  logic [31:0] period_next;
  logic        period_hit;
  logic        is_final;
  logic        offer_ok;
  logic        offer_after_hs;

  // Whether the beat that would be offered with this period/count state
  // carries tlast.
  function automatic logic last_for(input logic [31:0] period, input logic [31:0] count);
    last_for = ((LAST_PERIOD != 32'd0) && (period == LAST_PERIOD - 32'd1)) ||
               ((BEAT_COUNT != 32'd0) && (count + 32'd1 == BEAT_COUNT));
  endfunction

  assign hs = valid_q & output_ready;

  always_comb begin
    src_next = src_q;
    if (MODE == 1) begin
      src_next = (src_q >> 1) ^ (src_q[0] ? LFSR_TAPS : 32'd0);
    end else if (MODE == 0) begin
      // Masking to DATA_WIDTH gives the silent modulo-2^DATA_WIDTH wrap.
      src_next = (src_q + STEP) & DATA_MASK;
    end
  end

  assign count_next  = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
  assign period_hit  = (LAST_PERIOD != 32'd0) && (period_q == LAST_PERIOD - 32'd1);
  assign period_next = ((LAST_PERIOD == 32'd0) || period_hit) ? 32'd0 : period_q + 32'd1;
  assign is_final    = (BEAT_COUNT != 32'd0) && (count_q + 32'd1 == BEAT_COUNT);

`ifdef HELPER_AXIS_GEN_THROTTLE_EN
  logic [7:0] thr_q, thr_d;
  logic [1:0] gap_q, gap_d;

  // gap_q counts the idle cycles still owed after a handshake. A beat may be
  // offered on the edge that takes gap_q to 0.
  always_comb begin
    thr_d = thr_q;
    gap_d = (gap_q != 2'd0) ? gap_q - 2'd1 : gap_q;
    if (hs) begin
      thr_d = {thr_q[6:0], thr_q[7] ^ thr_q[5] ^ thr_q[4] ^ thr_q[3]};
      gap_d = thr_q[1:0];
    end
  end

  assign offer_ok       = (gap_q <= 2'd1);
  assign offer_after_hs = (thr_q[1:0] == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q <= 8'hA5;
      gap_q <= 2'd0;
    end else begin
      thr_q <= thr_d;
      gap_q <= gap_d;
    end
  end
`else
  assign offer_ok       = 1'b1;
  assign offer_after_hs = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = done_q;
    src_d    = src_q;
    count_d  = count_q;
    period_d = period_q;

    if (hs) begin
      src_d    = src_next;
      count_d  = count_next;
      period_d = period_next;
    end

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (enable) begin
          state_d = S_RUN;
          if (offer_ok) begin
            valid_d = 1'b1;
            last_d  = last_for(period_q, count_q);
          end
        end
      end

      S_RUN: begin
        if (hs) begin
          if (is_final) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!enable) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            valid_d = offer_after_hs;
            last_d  = offer_after_hs & last_for(period_next, count_next);
          end
        end else if (valid_q) begin
          // Pending beat: never withdraw it, just park in HOLD.
          if (!enable) begin
            state_d = S_HOLD;
          end
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (offer_ok) begin
          valid_d = 1'b1;
          last_d  = last_for(period_q, count_q);
        end
      end

      S_HOLD: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (is_final) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      src_q    <= SRC_RESET;
      count_q  <= 32'd0;
      period_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      src_q    <= src_d;
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

  assign output_valid = valid_q;
  assign output_data  = src_q[DATA_WIDTH-1:0];
  assign output_last  = last_q;
  assign done         = done_q;
  assign beat_count   = count_q;

  // The upper LFSR bits feed only the next state when DATA_WIDTH < 32.
  logic unused_src_bits;
  assign unused_src_bits = ^src_q;

endmodule
